sonar_ping_sequencer: RTL and testbench

//  Sequences ping bursts for the sonar transmit chain. On start, runs N pings:
//  TX (drives enable/pattern of the pulse generator), GUARD (blanking while the

---
 rtl/sonar_ping_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_sonar_ping_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_ping_sequencer.sv
// Ping burst sequencer: TX -> GUARD -> LISTEN per ping, rotating through a latched pattern table.
// Optional SONAR_SEQ_TIMESTAMP_EN adds a free-running cycle counter and the ping_ts output.
module sonar_ping_sequencer #(
  parameter int NPAT  = 4,
  parameter int PAT_W = 32,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               num_pings,
  input  logic [$clog2(NPAT)-1:0]  pat_cnt,
  input  logic [NPAT*PAT_W-1:0]    pat_table,
  input  logic [CNT_W-1:0]         tx_cycles,
  input  logic [15:0]              guard_cycles,
  input  logic [CNT_W-1:0]         listen_cycles,
  output logic                     pg_enable,
  output logic [PAT_W-1:0]         pg_pattern,
  output logic                     rx_window,
  output logic                     ping_start,
  output logic [7:0]               ping_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
`ifdef SONAR_SEQ_TIMESTAMP_EN
  ,
  output logic [31:0]              ping_ts
`endif
);

  localparam int IW = $clog2(NPAT);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_GUARD, S_LISTEN, S_END} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       tx_last_q, tx_last_d;
  logic [CNT_W-1:0]       listen_q, listen_d;
  logic [15:0]            guard_q, guard_d;
  logic [7:0]             num_q, num_d;
  logic [7:0]             ping_idx_q, ping_idx_d;
  logic [IW-1:0]          pat_cnt_q, pat_cnt_d;
  logic [IW-1:0]          pat_idx_q, pat_idx_d;
  logic [IW-1:0]          pat_next;
  logic [NPAT*PAT_W-1:0]  table_q, table_d;
  logic [PAT_W-1:0]       pg_pattern_q, pg_pattern_d;
  logic                   pg_enable_q, pg_enable_d;
  logic                   rx_window_q, rx_window_d;
  logic                   ping_start_q, ping_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic [CNT_W-1:0]       tx_load_in;
  logic                   last_ping;

  // Counters hold "cycles remaining minus one", so a zero tx_cycles still gives one TX cycle.
  assign tx_load_in = (tx_cycles == '0) ? '0 : tx_cycles - 1'b1;
  assign pat_next   = (pat_idx_q == pat_cnt_q) ? '0 : pat_idx_q + 1'b1;
  assign last_ping  = (num_q != 8'd0) && ((ping_idx_q + 8'd1) == num_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_last_d    = tx_last_q;
    listen_d     = listen_q;
    guard_d      = guard_q;
    num_d        = num_q;
    ping_idx_d   = ping_idx_q;
    pat_cnt_d    = pat_cnt_q;
    pat_idx_d    = pat_idx_q;
    table_d      = table_q;
    pg_pattern_d = pg_pattern_q;
    pg_enable_d  = pg_enable_q;
    rx_window_d  = rx_window_q;
    busy_d       = busy_q;
    ping_start_d = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          num_d        = num_pings;
          pat_cnt_d    = pat_cnt;
          table_d      = pat_table;
          tx_last_d    = tx_load_in;
          guard_d      = guard_cycles;
          listen_d     = listen_cycles;
          state_d      = S_TX;
          cnt_d        = tx_load_in;
          ping_idx_d   = 8'd0;
          pat_idx_d    = '0;
          pg_pattern_d = pat_table[PAT_W-1:0];
          pg_enable_d  = 1'b1;
          ping_start_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      S_TX, S_GUARD, S_LISTEN: begin
        if (abort) begin
          state_d     = S_END;
          pg_enable_d = 1'b0;
          rx_window_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          aborted_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (state_q == S_TX && guard_q != 16'd0) begin
          state_d     = S_GUARD;
          cnt_d       = CNT_W'(guard_q - 16'd1);
          pg_enable_d = 1'b0;
        end else if (state_q != S_LISTEN && listen_q != '0) begin
          state_d     = S_LISTEN;
          cnt_d       = listen_q - 1'b1;
          pg_enable_d = 1'b0;
          rx_window_d = 1'b1;
        end else if (!last_ping) begin
          state_d      = S_TX;
          cnt_d        = tx_last_q;
          ping_idx_d   = ping_idx_q + 8'd1;
          pat_idx_d    = pat_next;
          pg_pattern_d = table_q[pat_next*PAT_W +: PAT_W];
          pg_enable_d  = 1'b1;
          rx_window_d  = 1'b0;
          ping_start_d = 1'b1;
        end else begin
          state_d     = S_END;
          pg_enable_d = 1'b0;
          rx_window_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end
      // The burst is already finishing here, so start and abort are both ignored.
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tx_last_q    <= '0;
      listen_q     <= '0;
      guard_q      <= '0;
      num_q        <= '0;
      ping_idx_q   <= '0;
      pat_cnt_q    <= '0;
      pat_idx_q    <= '0;
      table_q      <= '0;
      pg_pattern_q <= '0;
      pg_enable_q  <= 1'b0;
      rx_window_q  <= 1'b0;
      ping_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_last_q    <= tx_last_d;
      listen_q     <= listen_d;
      guard_q      <= guard_d;
      num_q        <= num_d;
      ping_idx_q   <= ping_idx_d;
      pat_cnt_q    <= pat_cnt_d;
      pat_idx_q    <= pat_idx_d;
      table_q      <= table_d;
      pg_pattern_q <= pg_pattern_d;
      pg_enable_q  <= pg_enable_d;
      rx_window_q  <= rx_window_d;
      ping_start_q <= ping_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign pg_enable  = pg_enable_q;
  assign pg_pattern = pg_pattern_q;
  assign rx_window  = rx_window_q;
  assign ping_start = ping_start_q;
  assign ping_idx   = ping_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

`ifdef SONAR_SEQ_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d;
  logic [31:0] ping_ts_q, ping_ts_d;

  // ping_ts carries the counter value of the ping_start cycle itself.
  always_comb begin
    ts_cnt_d  = ts_cnt_q + 32'd1;
    ping_ts_d = ping_start_d ? ts_cnt_d : ping_ts_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_cnt_q  <= '0;
      ping_ts_q <= '0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      ping_ts_q <= ping_ts_d;
    end
  end

  assign ping_ts = ping_ts_q;
`endif

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Scoreboard bench for sonar_ping_sequencer: expected per-cycle output traces are queued
// when a burst is started and popped against the DUT each cycle.
module tb_sonar_ping_sequencer;

  localparam int NPAT  = 4;
  localparam int PAT_W = 32;
  localparam int CNT_W = 32;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic [7:0]              num_pings = '0;
  logic [1:0]              pat_cnt = '0;
  logic [NPAT*PAT_W-1:0]   pat_table = '0;
  logic [CNT_W-1:0]        tx_cycles = '0;
  logic [15:0]             guard_cycles = '0;
  logic [CNT_W-1:0]        listen_cycles = '0;
  logic                    pg_enable;
  logic [PAT_W-1:0]        pg_pattern;
  logic                    rx_window;
  logic                    ping_start;
  logic [7:0]              ping_idx;
  logic                    busy;
  logic                    done;
  logic                    aborted;
`ifdef SONAR_SEQ_TIMESTAMP_EN
  logic [31:0]             ping_ts;
`endif

  typedef struct packed {
    logic        en;
    logic        rx;
    logic        ps;
    logic        busy;
    logic        done;
    logic        ab;
    logic [7:0]  idx;
    logic [31:0] pat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tbl[NPAT];
  logic [7:0]  last_idx = '0;
  logic [31:0] last_pat = '0;
  int          total = 0;
  int          bad = 0;

  sonar_ping_sequencer #(.NPAT(NPAT), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .num_pings(num_pings), .pat_cnt(pat_cnt), .pat_table(pat_table),
    .tx_cycles(tx_cycles), .guard_cycles(guard_cycles), .listen_cycles(listen_cycles),
    .pg_enable(pg_enable), .pg_pattern(pg_pattern), .rx_window(rx_window),
    .ping_start(ping_start), .ping_idx(ping_idx), .busy(busy), .done(done),
    .aborted(aborted)
`ifdef SONAR_SEQ_TIMESTAMP_EN
    , .ping_ts(ping_ts)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t observe();
    return '{en: pg_enable, rx: rx_window, ps: ping_start, busy: busy, done: done,
             ab: aborted, idx: ping_idx, pat: pg_pattern};
  endfunction

  function automatic exp_t idle_rec();
    return '{en: 1'b0, rx: 1'b0, ps: 1'b0, busy: 1'b0, done: 1'b0, ab: 1'b0,
             idx: last_idx, pat: last_pat};
  endfunction

  function automatic exp_t end_rec(input logic was_abort);
    return '{en: 1'b0, rx: 1'b0, ps: 1'b0, busy: 1'b0, done: 1'b1, ab: was_abort,
             idx: last_idx, pat: last_pat};
  endfunction

  // Reference trace of one burst, built phase by phase from the configuration.
  task automatic gen_burst(input int pings, input int tx, input int guard, input int listen,
                           input int patcnt, input bit add_end);
    int   pat;
    exp_t e;
    pat = 0;
    for (int p = 0; p < pings; p++) begin
      for (int c = 0; c < ((tx == 0) ? 1 : tx); c++) begin
        e = '{en: 1'b1, rx: 1'b0, ps: (c == 0), busy: 1'b1, done: 1'b0, ab: 1'b0,
              idx: 8'(p), pat: tbl[pat]};
        sb.push_back(e);
      end
      for (int c = 0; c < guard; c++) begin
        e = '{en: 1'b0, rx: 1'b0, ps: 1'b0, busy: 1'b1, done: 1'b0, ab: 1'b0,
              idx: 8'(p), pat: tbl[pat]};
        sb.push_back(e);
      end
      for (int c = 0; c < listen; c++) begin
        e = '{en: 1'b0, rx: 1'b1, ps: 1'b0, busy: 1'b1, done: 1'b0, ab: 1'b0,
              idx: 8'(p), pat: tbl[pat]};
        sb.push_back(e);
      end
      last_idx = 8'(p);
      last_pat = tbl[pat];
      pat = (pat == patcnt) ? 0 : pat + 1;
    end
    if (add_end) begin
      sb.push_back(end_rec(1'b0));
      sb.push_back(idle_rec());
      sb.push_back(idle_rec());
    end
  endtask

  task automatic launch(input int n, input int tx, input int g, input int l, input int pc);
    @(negedge clk);
    num_pings     = 8'(n);
    tx_cycles     = CNT_W'(tx);
    guard_cycles  = 16'(g);
    listen_cycles = CNT_W'(l);
    pat_cnt       = 2'(pc);
    start         = 1'b1;
  endtask

  task automatic test_reset();
    exp_t o;
    rstn = 1'b0;
    #1;
    o = observe();
    total++;
    if (o !== idle_rec()) begin
      bad++;
      $display("[TB] FAIL reset_state: got %h want %h", o, idle_rec());
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    o = observe();
    total++;
    if (o !== idle_rec()) begin
      bad++;
      $display("[TB] FAIL reset_release: got %h want %h", o, idle_rec());
    end
  endtask

  task automatic test_basic();
    exp_t e, o;
    int   i;
    launch(2, 10, 5, 20, 1);
    gen_burst(2, 10, 5, 20, 1, 1'b1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL basic cyc%0d: got %h want %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_zero_lengths();
    exp_t e, o;
    int   i;
    launch(3, 0, 0, 0, 3);
    gen_burst(3, 0, 0, 0, 3, 1'b1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL zero_len cyc%0d: got %h want %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_ignore_start();
    exp_t e, o;
    int   i;
    launch(2, 3, 2, 3, 1);
    gen_burst(2, 3, 2, 3, 1, 1'b1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL ignore_start cyc%0d: got %h want %h", i, o, e);
      end
      if (i == 4 || e.done) start = 1'b1;
      i++;
    end
    start = 1'b0;
  endtask

  task automatic test_cfg_latch();
    exp_t e, o;
    int   i;
    launch(3, 10, 1, 2, 1);
    gen_burst(3, 10, 1, 2, 1, 1'b1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 2) begin
        tx_cycles     = 3;
        guard_cycles  = 0;
        listen_cycles = 0;
        num_pings     = 1;
        pat_cnt       = 0;
      end
      e = sb.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL cfg_latch cyc%0d: got %h want %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_continuous_abort();
    exp_t e, o;
    int   i;
    launch(0, 2, 1, 4, 1);
    gen_burst(3, 2, 1, 4, 1, 1'b0);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      e = sb.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL cont_abort cyc%0d: got %h want %h", i, o, e);
      end
      // Second cycle of the third LISTEN window.
      if (i == 18) begin
        abort = 1'b1;
        sb.delete();
        sb.push_back(end_rec(1'b1));
        sb.push_back(idle_rec());
        sb.push_back(idle_rec());
      end
      i++;
    end
    abort = 1'b0;
  endtask

  task automatic test_abort_idle();
    exp_t o;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      o = observe();
      total++;
      if (o !== idle_rec()) begin
        bad++;
        $display("[TB] FAIL abort_idle cyc%0d: got %h want %h", i, o, idle_rec());
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    int   i;
    launch(1, 10, 0, 0, 0);
    gen_burst(1, 10, 0, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL reset_mid_tx cyc%0d: got %h want %h", k, o, e);
      end
    end
    sb.delete();
    #2 rstn = 1'b0;
    last_idx = '0;
    last_pat = '0;
    #1;
    o = observe();
    total++;
    if (o !== idle_rec()) begin
      bad++;
      $display("[TB] FAIL reset_mid_async: got %h want %h", o, idle_rec());
    end
    @(negedge clk);
    rstn = 1'b1;
    launch(1, 1, 0, 1, 2);
    gen_burst(1, 1, 0, 1, 2, 1'b1);
    i = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("[TB] FAIL reset_mid_restart cyc%0d: got %h want %h", i, o, e);
      end
      i++;
    end
  endtask

  initial begin
    tbl[0] = 32'hA5A5_0001;
    tbl[1] = 32'h5A5A_0002;
    tbl[2] = 32'hF00D_0003;
    tbl[3] = 32'hC0DE_0004;
    pat_table = {tbl[3], tbl[2], tbl[1], tbl[0]};
    test_reset();
    test_basic();
    test_zero_lengths();
    test_ignore_start();
    test_cfg_latch();
    test_continuous_abort();
    test_abort_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
